// File: rtl/keypad_pkg.sv
// Shared key codes, row encodings and FSM states for the keypad scanner/decoder.
// Key codes are the values presented to the password logic; KEY_MULTI is internal only.
package keypad_pkg;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;
    localparam logic [3:0] KEY_MULTI = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    localparam logic [3:0] ROW_0 = 4'b0001;
    localparam logic [3:0] ROW_1 = 4'b0010;
    localparam logic [3:0] ROW_2 = 4'b0100;
    localparam logic [3:0] ROW_3 = 4'b1000;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } kp_state_t;

    // Only meaningful when exactly one column bit is set.
    function automatic logic [3:0] key_lookup(input logic [3:0] row_oh, input logic [2:0] col_oh);
        logic [1:0] c;
        logic [3:0] code;
        c = col_oh[2] ? 2'd2 : (col_oh[1] ? 2'd1 : 2'd0);
        case (row_oh)
            ROW_0:   code = (c == 2'd0) ? KEY_1    : ((c == 2'd1) ? KEY_2 : KEY_3);
            ROW_1:   code = (c == 2'd0) ? KEY_4    : ((c == 2'd1) ? KEY_5 : KEY_6);
            ROW_2:   code = (c == 2'd0) ? KEY_7    : ((c == 2'd1) ? KEY_8 : KEY_9);
            ROW_3:   code = (c == 2'd0) ? KEY_STAR : ((c == 2'd1) ? KEY_0 : KEY_SHARP);
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Keypad matrix pins plus the decoded key event/status outputs.
// master = decoder side, slave = keypad matrix and key consumer side.
interface keypad_decoder_if;
    logic [2:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;

    modport master (
        input  col,
        output row, key_code, key_valid, key_held, key_release
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_held, key_release
    );
endinterface

// File: rtl/keypad_row_scanner.sv
// Drives one-hot rows, each held for SCAN_DIV cycles; strobes on the last dwell cycle.
// Latency: free-running, frame_end every 4*SCAN_DIV cycles; no backpressure.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000000
) (
    input  logic       clk,
    input  logic       init_n,
    output logic [3:0] row,
    output logic       sample_stb,
    output logic       frame_end
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cnt_q <= '0;
            row   <= ROW_0;
        end else if (sample_stb) begin
            cnt_q <= '0;
            row   <= {row[2:0], row[3]};
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Sampling on the final dwell cycle gives the columns the longest settling time.
    assign sample_stb = (cnt_q == CNT_LAST);
    assign frame_end  = sample_stb & row[3];

endmodule

// File: rtl/keypad_decoder.sv
// Scans a 4x3 keypad, debounces whole frames and emits press/held/release events.
// Latency: press accepted within DEBOUNCE_SCANS+1 frames; no backpressure (events are pulses).
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000000,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic              clk,
    input  logic              init_n,
    keypad_decoder_if.master  kp
);

    localparam int            SW       = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic [3:0] row_scan;
    logic       sample_stb;
    logic       frame_end;

    keypad_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk        (clk),
        .init_n     (init_n),
        .row        (row_scan),
        .sample_stb (sample_stb),
        .frame_end  (frame_end)
    );

    // Frame accumulation: bit count saturates at 2, which already means MULTI.
    logic [1:0] acc_bits_q;
    logic [3:0] acc_code_q;
    logic [1:0] row_bits;
    logic [3:0] row_code;
    logic [2:0] bit_sum;
    logic [1:0] tot_bits;
    logic [3:0] merged_code;
    logic [3:0] frame_result;

    always_comb begin
        row_bits = 2'd0;
        case (kp.col)
            3'b000:                 row_bits = 2'd0;
            3'b001, 3'b010, 3'b100: row_bits = 2'd1;
            default:                row_bits = 2'd2;
        endcase
        row_code     = key_lookup(row_scan, kp.col);
        bit_sum      = {1'b0, acc_bits_q} + {1'b0, row_bits};
        tot_bits     = (bit_sum >= 3'd2) ? 2'd2 : bit_sum[1:0];
        merged_code  = (acc_bits_q == 2'd1) ? acc_code_q : row_code;
        frame_result = KEY_NONE;
        if (tot_bits == 2'd1) begin
            frame_result = merged_code;
        end else if (tot_bits == 2'd2) begin
            frame_result = KEY_MULTI;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            acc_bits_q <= 2'd0;
            acc_code_q <= KEY_NONE;
        end else if (sample_stb) begin
            if (frame_end) begin
                acc_bits_q <= 2'd0;
                acc_code_q <= KEY_NONE;
            end else begin
                acc_bits_q <= tot_bits;
                acc_code_q <= merged_code;
            end
        end
    end

    // Debounce across frames.
    logic [3:0]    cand_q;
    logic [SW-1:0] stab_q;
    logic [SW-1:0] stab_d;
    logic          stable;

    always_comb begin
        stab_d = '0;
        if (frame_result == cand_q) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
        end
        stable = frame_end && (stab_d == STAB_MAX);
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cand_q <= KEY_NONE;
            stab_q <= '0;
        end else if (frame_end) begin
            cand_q <= frame_result;
            stab_q <= stab_d;
        end
    end

    // Press/release FSM; a held key locks out every other key until released.
    kp_state_t  state_q, state_d;
    logic [3:0] code_q, code_d;
    logic       held_q, held_d;
    logic       valid_q, valid_d;
    logic       rel_q, rel_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (stable && frame_result != KEY_NONE && frame_result != KEY_MULTI) begin
                    code_d  = frame_result;
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (stable && frame_result == KEY_NONE) begin
                    held_d  = 1'b0;
                    rel_d   = 1'b1;
                    state_d = ST_RELEASED;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= ST_RELEASED;
            code_q  <= KEY_NONE;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
        end
    end

    assign kp.row         = row_scan;
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_held    = held_q;
    assign kp.key_release = rel_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench: frame-aligned key vectors against hand-computed press/release timing.
module tb_keypad_decoder;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int FR = 4 * SD;

    logic clk = 1'b0;
    logic init_n = 1'b0;

    keypad_decoder_if kif();

    keypad_decoder #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk    (clk),
        .init_n (init_n),
        .kp     (kif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pressed-key mask, bit index = row*3 + col.
    logic [11:0] mask = 12'h000;

    typedef struct {
        logic [11:0] mask;
        int          nfr;
        int          vfr;
        int          rfr;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t vecs[16];

    int vcnt, vtick, rcnt, rtick, ovl, longp, quiet;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_col();
        logic [2:0] c;
        c = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (kif.row[r]) c = c | mask[r*3 +: 3];
        end
        kif.col = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_col();
    endtask

    task automatic run_frames(input logic [11:0] m, input int nfr);
        logic pv, pr;
        mask = m;
        drive_col();
        vcnt = 0; vtick = 0; rcnt = 0; rtick = 0; ovl = 0; longp = 0;
        pv = 1'b0; pr = 1'b0;
        for (int t = 1; t <= nfr * FR; t++) begin
            tick();
            if (kif.key_valid === 1'b1) begin vcnt++; vtick = t; end
            if (kif.key_release === 1'b1) begin rcnt++; rtick = t; end
            if (kif.key_valid === 1'b1 && kif.key_release === 1'b1) ovl++;
            if ((kif.key_valid === 1'b1 && pv) || (kif.key_release === 1'b1 && pr)) longp++;
            pv = (kif.key_valid === 1'b1);
            pr = (kif.key_release === 1'b1);
        end
    endtask

    initial begin
        vecs[0]  = '{12'h000,               2, 0, 0, 4'd15, 1'b0};
        vecs[1]  = '{12'h010,               4, 2, 0, 4'd5,  1'b1};
        vecs[2]  = '{12'h000,               2, 0, 2, 4'd5,  1'b0};
        vecs[3]  = '{12'h100,               1, 0, 0, 4'd5,  1'b0};
        vecs[4]  = '{12'h000,               1, 0, 0, 4'd5,  1'b0};
        vecs[5]  = '{12'h100,               2, 2, 0, 4'd9,  1'b1};
        vecs[6]  = '{12'h000,               2, 0, 2, 4'd9,  1'b0};
        vecs[7]  = '{12'h101,               3, 0, 0, 4'd9,  1'b0};
        vecs[8]  = '{12'h200,               2, 2, 0, 4'd10, 1'b1};
        vecs[9]  = '{12'h000,               2, 0, 2, 4'd10, 1'b0};
        vecs[10] = '{12'h800,               2, 2, 0, 4'd11, 1'b1};
        vecs[11] = '{12'h810,               2, 0, 0, 4'd11, 1'b1};
        vecs[12] = '{12'h400,               2, 0, 0, 4'd11, 1'b1};
        vecs[13] = '{12'h000,               2, 0, 2, 4'd11, 1'b0};
        vecs[14] = '{12'h003,               3, 0, 0, 4'd11, 1'b0};
        vecs[15] = '{12'h080,               2, 2, 0, 4'd8,  1'b1};

        kif.col = 3'b000;
        #12;
        check("rst row",     kif.row,         4'b0001);
        check("rst code",    kif.key_code,    4'hF);
        check("rst valid",   kif.key_valid,   1'b0);
        check("rst held",    kif.key_held,    1'b0);
        check("rst release", kif.key_release, 1'b0);

        @(posedge clk);
        #1;
        init_n = 1'b1;
        drive_col();
        check("scan row t0", kif.row, 4'b0001);
        quiet = 0;
        for (int t = 1; t <= FR; t++) begin
            logic [3:0] exp_row;
            tick();
            exp_row = ROW_0 << ((t / SD) % 4);
            check($sformatf("scan row t%0d", t), kif.row, exp_row);
            if (kif.key_valid !== 1'b0 || kif.key_release !== 1'b0 || kif.key_held !== 1'b0 ||
                kif.key_code !== 4'hF) quiet++;
        end
        check("scan outputs idle", quiet, 0);

        for (int i = 0; i < 16; i++) begin
            run_frames(vecs[i].mask, vecs[i].nfr);
            check($sformatf("v%0d valid count", i), vcnt, (vecs[i].vfr > 0) ? 1 : 0);
            if (vecs[i].vfr > 0) check($sformatf("v%0d valid tick", i), vtick, vecs[i].vfr * FR);
            check($sformatf("v%0d release count", i), rcnt, (vecs[i].rfr > 0) ? 1 : 0);
            if (vecs[i].rfr > 0) check($sformatf("v%0d release tick", i), rtick, vecs[i].rfr * FR);
            check($sformatf("v%0d key_code", i), kif.key_code, vecs[i].code);
            check($sformatf("v%0d key_held", i), kif.key_held, vecs[i].held);
            check($sformatf("v%0d overlap", i), ovl, 0);
            check($sformatf("v%0d long pulse", i), longp, 0);
        end

        // Reset mid-dwell on row 2 while key 8 is held.
        for (int t = 0; t < 9; t++) tick();
        check("mid row before reset", kif.row, 4'b0100);
        check("mid held before reset", kif.key_held, 1'b1);
        #1;
        init_n = 1'b0;
        #1;
        check("async held", kif.key_held, 1'b0);
        check("async row",  kif.row,      4'b0001);
        check("async code", kif.key_code, 4'hF);
        check("async valid", kif.key_valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held in reset", kif.key_held, 1'b0);
        init_n = 1'b1;
        drive_col();
        run_frames(12'h080, 2);
        check("retrigger valid count", vcnt, 1);
        check("retrigger valid tick", vtick, 2 * FR);
        check("retrigger code", kif.key_code, 4'd8);
        check("retrigger held", kif.key_held, 1'b1);
        check("retrigger release", rcnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
